map_table: RTL and testbench

MAP_TABLE -- requirements
Module: map_table

---
 rtl/sys_defs.sv | 21 ++
 rtl/map_table.sv | 84 ++++++++
 tb/tb_map_table.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sys_defs.sv
// Shared rename/issue definitions: ROB sizing and the packet the map table
// hands to the reservation station.
package sys_defs;

    localparam int ROB_SIZE  = 8;
    localparam int TAG_WIDTH = $clog2(ROB_SIZE);
    localparam int REG_IDX_W = 5;

    typedef struct packed {
        logic                 busy;
        logic [TAG_WIDTH-1:0] tag;
        logic                 tag_ready;
    } SRC_MAP;

    typedef struct packed {
        SRC_MAP               rs1;
        SRC_MAP               rs2;
        logic [TAG_WIDTH-1:0] dest_tag;
    } MAPPED_REG_PACKET;

endpackage

// File: rtl/map_table.sv
// Register rename map: architectural register -> producing ROB tag, with
// CDB readiness tracking, zero-latency source lookup and flush recovery.
module map_table #(
    parameter int NUM_ARCH_REGS = 32,
    parameter int TAG_WIDTH     = sys_defs::TAG_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       dispatch_valid,
    input  logic [4:0]                 rs1_idx,
    input  logic [4:0]                 rs2_idx,
    input  logic [4:0]                 dest_idx,
    input  logic                       dest_valid,
    input  logic [TAG_WIDTH-1:0]       rob_tag,
    input  logic                       cdb_valid,
    input  logic [TAG_WIDTH-1:0]       cdb_tag,
    input  logic                       retire_valid,
    input  logic [4:0]                 retire_idx,
    input  logic [TAG_WIDTH-1:0]       retire_tag,
    input  logic                       flush,
    output sys_defs::MAPPED_REG_PACKET mapped_reg_packet
);

    typedef struct packed {
        logic                 busy;
        logic [TAG_WIDTH-1:0] tag;
        logic                 tag_ready;
    } MAP_ENTRY;

    MAP_ENTRY [NUM_ARCH_REGS-1:0] map_q, map_d;

    logic disp_wr;
    assign disp_wr = dispatch_valid && dest_valid && (dest_idx != 5'd0);

    // Lookup sees the pre-dispatch table; the CDB is bypassed so a source
    // completing this cycle is already reported ready.
    function automatic sys_defs::SRC_MAP lookup(input logic [4:0] idx, input MAP_ENTRY e);
        sys_defs::SRC_MAP s;
        s = '0;
        if (idx != 5'd0 && e.busy) begin
            s.busy      = 1'b1;
            s.tag       = e.tag;
            s.tag_ready = e.tag_ready || (cdb_valid && cdb_tag == e.tag);
        end
        return s;
    endfunction

    always_comb begin
        mapped_reg_packet          = '0;
        mapped_reg_packet.rs1      = lookup(rs1_idx, map_q[rs1_idx]);
        mapped_reg_packet.rs2      = lookup(rs2_idx, map_q[rs2_idx]);
        mapped_reg_packet.dest_tag = rob_tag;
    end

    // Priority per entry: CDB, then retire, then dispatch (newest mapping wins);
    // flush overrides everything.
    always_comb begin
        map_d = map_q;
        for (int i = 1; i < NUM_ARCH_REGS; i++) begin
            if (cdb_valid && map_q[i].busy && map_q[i].tag == cdb_tag)
                map_d[i].tag_ready = 1'b1;
            if (retire_valid && retire_idx == 5'(i) && map_q[i].tag == retire_tag)
                map_d[i].busy = 1'b0;
            if (disp_wr && dest_idx == 5'(i)) begin
                map_d[i].busy      = 1'b1;
                map_d[i].tag       = rob_tag;
                map_d[i].tag_ready = 1'b0;
            end
        end
        map_d[0] = '0;
        if (flush) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                map_d[i].busy      = 1'b0;
                map_d[i].tag_ready = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) map_q <= '0;
        else        map_q <= map_d;
    end

endmodule

// File: tb/tb_map_table.sv
// Directed bench for map_table: hand-computed lookups across dispatch, CDB,
// retire, flush and asynchronous reset scenarios.
module tb_map_table;

    logic       clk = 1'b0;
    logic       reset;
    logic       dispatch_valid;
    logic [4:0] rs1_idx, rs2_idx, dest_idx;
    logic       dest_valid;
    logic [2:0] rob_tag;
    logic       cdb_valid;
    logic [2:0] cdb_tag;
    logic       retire_valid;
    logic [4:0] retire_idx;
    logic [2:0] retire_tag;
    logic       flush;
    sys_defs::MAPPED_REG_PACKET pkt;

    int total = 0;
    int bad   = 0;

    map_table dut (
        .clk(clk), .reset(reset), .dispatch_valid(dispatch_valid),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .dest_idx(dest_idx),
        .dest_valid(dest_valid), .rob_tag(rob_tag), .cdb_valid(cdb_valid),
        .cdb_tag(cdb_tag), .retire_valid(retire_valid), .retire_idx(retire_idx),
        .retire_tag(retire_tag), .flush(flush), .mapped_reg_packet(pkt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dispatch_valid = 0; dest_valid = 0; dest_idx = 0; rob_tag = 0;
        cdb_valid = 0; cdb_tag = 0; retire_valid = 0; retire_idx = 0;
        retire_tag = 0; flush = 0;
    endtask

    task automatic disp(input logic [4:0] d, input logic [2:0] t);
        dispatch_valid = 1; dest_valid = 1; dest_idx = d; rob_tag = t;
    endtask

    initial begin
        idle();
        rs1_idx = 0; rs2_idx = 0;
        reset = 0;
        // dispatch while held in reset must be discarded
        #1;
        disp(5'd4, 3'd7);
        rs1_idx = 5'd4;
        #1;
        chk("reset_busy", pkt.rs1.busy, 0);
        chk("reset_tag", pkt.rs1.tag, 0);
        chk("reset_dest_tag", pkt.dest_tag, 7);
        #15;
        reset = 1;
        idle();
        #1;
        chk("post_reset_x4_busy", pkt.rs1.busy, 0);

        // add x5 tagged 2, then read it back
        tick();
        disp(5'd5, 3'd2);
        rs1_idx = 5'd5;
        #1;
        chk("disp_dest_tag", pkt.dest_tag, 2);
        chk("x5_pre_dispatch", pkt.rs1.busy, 0);
        tick();
        idle();
        rs1_idx = 5'd5; rs2_idx = 5'd6;
        #1;
        chk("x5_busy", pkt.rs1.busy, 1);
        chk("x5_tag", pkt.rs1.tag, 2);
        chk("x5_not_ready", pkt.rs1.tag_ready, 0);
        chk("x6_busy", pkt.rs2.busy, 0);
        chk("x6_tag", pkt.rs2.tag, 0);

        // same-cycle CDB bypass, then latched in the entry
        cdb_valid = 1; cdb_tag = 3'd2;
        #1;
        chk("x5_cdb_bypass", pkt.rs1.tag_ready, 1);
        cdb_tag = 3'd3;
        #1;
        chk("x5_cdb_other_tag", pkt.rs1.tag_ready, 0);
        cdb_tag = 3'd2;
        tick();
        idle();
        #1;
        chk("x5_ready_latched", pkt.rs1.tag_ready, 1);
        chk("x5_still_busy", pkt.rs1.busy, 1);

        // remap x5 to tag 6; stale retire must not clear it
        disp(5'd5, 3'd6);
        tick();
        idle();
        retire_valid = 1; retire_idx = 5'd5; retire_tag = 3'd2;
        #1;
        chk("x5_remap_tag", pkt.rs1.tag, 6);
        chk("x5_remap_not_ready", pkt.rs1.tag_ready, 0);
        tick();
        idle();
        #1;
        chk("x5_stale_retire_busy", pkt.rs1.busy, 1);
        chk("x5_stale_retire_tag", pkt.rs1.tag, 6);
        retire_valid = 1; retire_idx = 5'd5; retire_tag = 3'd6;
        tick();
        idle();
        #1;
        chk("x5_retired_busy", pkt.rs1.busy, 0);
        chk("x5_retired_tag", pkt.rs1.tag, 0);
        chk("x5_retired_ready", pkt.rs1.tag_ready, 0);

        // x0 is never mapped
        disp(5'd0, 3'd4);
        tick();
        idle();
        rs1_idx = 5'd0;
        #1;
        chk("x0_busy", pkt.rs1.busy, 0);
        chk("x0_tag", pkt.rs1.tag, 0);

        // rs1 == dest sees the previous producer
        disp(5'd7, 3'd3);
        tick();
        disp(5'd7, 3'd1);
        rs1_idx = 5'd7;
        #1;
        chk("x7_prev_tag", pkt.rs1.tag, 3);
        chk("x7_prev_busy", pkt.rs1.busy, 1);
        chk("x7_dest_tag", pkt.dest_tag, 1);
        tick();
        idle();
        #1;
        chk("x7_new_tag", pkt.rs1.tag, 1);

        // dispatch and retire on the same register: dispatch wins
        disp(5'd8, 3'd2);
        tick();
        disp(5'd8, 3'd5);
        retire_valid = 1; retire_idx = 5'd8; retire_tag = 3'd2;
        tick();
        idle();
        rs1_idx = 5'd8;
        #1;
        chk("x8_disp_over_retire_busy", pkt.rs1.busy, 1);
        chk("x8_disp_over_retire_tag", pkt.rs1.tag, 5);

        // broadcast of the tag being allocated does not mark it ready
        disp(5'd10, 3'd4);
        cdb_valid = 1; cdb_tag = 3'd4;
        tick();
        idle();
        rs1_idx = 5'd10;
        #1;
        chk("x10_busy", pkt.rs1.busy, 1);
        chk("x10_not_ready", pkt.rs1.tag_ready, 0);

        // fill x1..x31, then flush alongside a dispatch of x9
        for (int i = 1; i < 32; i++) begin
            disp(5'(i), 3'(i % 8));
            tick();
        end
        idle();
        rs1_idx = 5'd31; rs2_idx = 5'd1;
        #1;
        chk("x31_busy", pkt.rs1.busy, 1);
        chk("x31_tag", pkt.rs1.tag, 7);
        chk("x1_busy", pkt.rs2.busy, 1);
        chk("x1_tag", pkt.rs2.tag, 1);
        flush = 1;
        disp(5'd9, 3'd5);
        tick();
        idle();
        for (int i = 0; i < 32; i++) begin
            rs1_idx = 5'(i);
            #1;
            chk($sformatf("flush_x%0d_busy", i), pkt.rs1.busy, 0);
        end

        // asynchronous reset mid-cycle
        tick();
        disp(5'd3, 3'd3);
        tick();
        idle();
        rs1_idx = 5'd3;
        #1;
        chk("x3_busy_before_reset", pkt.rs1.busy, 1);
        #1;
        reset = 0;
        #1;
        chk("x3_async_cleared", pkt.rs1.busy, 0);
        chk("x3_async_tag", pkt.rs1.tag, 0);
        disp(5'd3, 3'd5);
        tick();
        tick();
        #1;
        chk("x3_disp_in_reset", pkt.rs1.busy, 0);
        chk("reset_dest_tag_follow", pkt.dest_tag, 5);
        reset = 1;
        idle();
        tick();
        #1;
        chk("x3_after_reset", pkt.rs1.busy, 0);
        disp(5'd3, 3'd6);
        tick();
        idle();
        #1;
        chk("x3_resume_busy", pkt.rs1.busy, 1);
        chk("x3_resume_tag", pkt.rs1.tag, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
